// File: rtl/lieat_axi_sram.sv
// lieat_axi_sram: AXI4 slave SRAM backing the core's 64-bit master port.
// Separate read and write state machines, FIXED/INCR bursts up to 256 beats,
// 4-bit IDs echoed on responses, SLVERR for out-of-range beats, WRAP/reserved
// bursts and sizes above 8 bytes.
// Optional feature macro: LIEAT_SRAM_DELAY_EN adds an R_WAIT state of DELAY
// cycles between the AR handshake and the first R beat.
module lieat_axi_sram #(
    parameter logic [31:0] BASE  = 32'h8000_0000,
    parameter int          DEPTH = 65536,
    parameter int          DELAY = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        io_slave_awready,
    input  logic        io_slave_awvalid,
    input  logic [31:0] io_slave_awaddr,
    input  logic [3:0]  io_slave_awid,
    input  logic [7:0]  io_slave_awlen,
    input  logic [2:0]  io_slave_awsize,
    input  logic [1:0]  io_slave_awburst,
    output logic        io_slave_wready,
    input  logic        io_slave_wvalid,
    input  logic [63:0] io_slave_wdata,
    input  logic [7:0]  io_slave_wstrb,
    input  logic        io_slave_wlast,
    input  logic        io_slave_bready,
    output logic        io_slave_bvalid,
    output logic [1:0]  io_slave_bresp,
    output logic [3:0]  io_slave_bid,
    output logic        io_slave_arready,
    input  logic        io_slave_arvalid,
    input  logic [31:0] io_slave_araddr,
    input  logic [3:0]  io_slave_arid,
    input  logic [7:0]  io_slave_arlen,
    input  logic [2:0]  io_slave_arsize,
    input  logic [1:0]  io_slave_arburst,
    input  logic        io_slave_rready,
    output logic        io_slave_rvalid,
    output logic [1:0]  io_slave_rresp,
    output logic [63:0] io_slave_rdata,
    output logic        io_slave_rlast,
    output logic [3:0]  io_slave_rid
);

    localparam int         IDX_W       = $clog2(DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
`ifdef LIEAT_SRAM_DELAY_EN
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
`else
    typedef enum logic [1:0] {R_IDLE, R_DATA} r_state_t;
`endif

    // Byte address inside [BASE, BASE + DEPTH*8)
    function automatic logic f_in_range(input logic [31:0] a);
        return ({32'd0, a} >= {32'd0, BASE}) &&
               ({32'd0, a} < ({32'd0, BASE} + 64'(DEPTH) * 64'd8));
    endfunction

    // Word index: byte offset from BASE with the 3 byte-lane bits dropped
    function automatic logic [IDX_W-1:0] f_index(input logic [31:0] a);
        return IDX_W'((a - BASE) >> 3);
    endfunction

    // Next beat address; only INCR moves, the error bursts simply stay put
    function automatic logic [31:0] f_step(input logic [31:0] a, input logic [2:0] size,
                                           input logic [1:0] burst);
        return (burst == 2'b01) ? (a + (32'd1 << size)) : a;
    endfunction

    // WRAP/reserved bursts and beats wider than the bus fail every beat
    function automatic logic f_req_bad(input logic [1:0] burst, input logic [2:0] size);
        return burst[1] || (size > 3'd3);
    endfunction

    // ---------------- write channel ----------------
    w_state_t    r_w_state;
    logic [31:0] r_waddr;
    logic [3:0]  r_wid;
    logic [7:0]  r_wlen;
    logic [2:0]  r_wsize;
    logic [1:0]  r_wburst;
    logic [7:0]  r_wcnt;
    logic        r_werr;
    logic        r_awready;
    logic        r_wready;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic [3:0]  r_bid;

    logic             w_w_req_bad;
    logic             w_w_in_range;
    logic             w_w_last_cnt;
    logic             w_w_beat_err;
    logic             w_mem_we;
    logic [IDX_W-1:0] w_mem_widx;

    assign w_w_req_bad  = f_req_bad(r_wburst, r_wsize);
    assign w_w_in_range = f_in_range(r_waddr);
    assign w_w_last_cnt = (r_wcnt == r_wlen);
    assign w_w_beat_err = w_w_req_bad | ~w_w_in_range | (io_slave_wlast != w_w_last_cnt);
    assign w_mem_we     = r_wready & io_slave_wvalid & ~w_w_req_bad & w_w_in_range;
    assign w_mem_widx   = f_index(r_waddr);

    // Write FSM: accept AW, collect beats, then hold B until it is taken
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_w_state <= W_IDLE;
            r_waddr   <= '0;
            r_wid     <= '0;
            r_wlen    <= '0;
            r_wsize   <= '0;
            r_wburst  <= '0;
            r_wcnt    <= '0;
            r_werr    <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_bid     <= '0;
        end else begin
            case (r_w_state)
                W_IDLE: begin
                    if (io_slave_awvalid) begin
                        r_waddr   <= io_slave_awaddr;
                        r_wid     <= io_slave_awid;
                        r_wlen    <= io_slave_awlen;
                        r_wsize   <= io_slave_awsize;
                        r_wburst  <= io_slave_awburst;
                        r_wcnt    <= '0;
                        r_werr    <= 1'b0;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (io_slave_wvalid) begin
                        if (w_w_last_cnt) begin
                            r_wready  <= 1'b0;
                            r_bvalid  <= 1'b1;
                            r_bresp   <= (r_werr | w_w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            r_bid     <= r_wid;
                            r_w_state <= W_RESP;
                        end else begin
                            r_wcnt  <= r_wcnt + 8'd1;
                            r_waddr <= f_step(r_waddr, r_wsize, r_wburst);
                            r_werr  <= r_werr | w_w_beat_err;
                        end
                    end
                end
                W_RESP: begin
                    if (io_slave_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_w_state <= W_IDLE;
                    end
                end
                default: r_w_state <= W_IDLE;
            endcase
        end
    end

    // ---------------- memory: one byte-wide array per lane ----------------
    logic [IDX_W-1:0] w_rd_idx;
    logic [63:0]      w_mem_rdata;

    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        logic [7:0] r_mem [DEPTH];

        // Byte-lane write; contents survive reset
        always_ff @(posedge clock) begin
            if (w_mem_we && io_slave_wstrb[gi]) begin
                r_mem[w_mem_widx] <= io_slave_wdata[gi*8 +: 8];
            end
        end

        assign w_mem_rdata[gi*8 +: 8] = r_mem[w_rd_idx];
    end

    // ---------------- read channel ----------------
    r_state_t    r_r_state;
    logic [31:0] r_raddr;
    logic [3:0]  r_rid;
    logic [7:0]  r_rlen;
    logic [2:0]  r_rsize;
    logic [1:0]  r_rburst;
    logic [7:0]  r_rcnt;
    logic        r_arready;
    logic        r_rvalid;
    logic [63:0] r_rdata;
    logic [1:0]  r_rresp;
    logic        r_rlast;
`ifdef LIEAT_SRAM_DELAY_EN
    logic [31:0] r_wait_cnt;
`else
    logic        w_unused_delay;
    assign w_unused_delay = ^DELAY;
`endif

    logic [31:0] w_rd_addr;
    logic        w_rd_bad;
    logic [7:0]  w_rd_cnt;
    logic [7:0]  w_rd_len;
    logic        w_rd_ok;
    logic        w_rd_last;

    // Address and beat number of the beat that would be loaded at the next edge
    always_comb begin
        w_rd_addr = r_raddr;
        w_rd_bad  = f_req_bad(r_rburst, r_rsize);
        w_rd_cnt  = r_rcnt;
        w_rd_len  = r_rlen;
        case (r_r_state)
            R_IDLE: begin
                w_rd_addr = io_slave_araddr;
                w_rd_bad  = f_req_bad(io_slave_arburst, io_slave_arsize);
                w_rd_cnt  = '0;
                w_rd_len  = io_slave_arlen;
            end
            R_DATA: begin
                w_rd_addr = f_step(r_raddr, r_rsize, r_rburst);
                w_rd_cnt  = r_rcnt + 8'd1;
            end
            default: ;
        endcase
    end

    assign w_rd_ok   = ~w_rd_bad & f_in_range(w_rd_addr);
    assign w_rd_idx  = f_index(w_rd_addr);
    assign w_rd_last = (w_rd_cnt == w_rd_len);

    // Read FSM: data is registered, so a beat is loaded on the edge before it is shown
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_r_state  <= R_IDLE;
            r_raddr    <= '0;
            r_rid      <= '0;
            r_rlen     <= '0;
            r_rsize    <= '0;
            r_rburst   <= '0;
            r_rcnt     <= '0;
            r_arready  <= 1'b1;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
            r_rlast    <= 1'b0;
`ifdef LIEAT_SRAM_DELAY_EN
            r_wait_cnt <= '0;
`endif
        end else begin
            case (r_r_state)
                R_IDLE: begin
                    if (io_slave_arvalid) begin
                        r_raddr   <= io_slave_araddr;
                        r_rid     <= io_slave_arid;
                        r_rlen    <= io_slave_arlen;
                        r_rsize   <= io_slave_arsize;
                        r_rburst  <= io_slave_arburst;
                        r_rcnt    <= '0;
                        r_arready <= 1'b0;
                        r_rdata   <= w_rd_ok ? w_mem_rdata : 64'd0;
                        r_rresp   <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
                        r_rlast   <= w_rd_last;
`ifdef LIEAT_SRAM_DELAY_EN
                        if (DELAY > 0) begin
                            r_wait_cnt <= '0;
                            r_r_state  <= R_WAIT;
                        end else begin
                            r_rvalid  <= 1'b1;
                            r_r_state <= R_DATA;
                        end
`else
                        r_rvalid  <= 1'b1;
                        r_r_state <= R_DATA;
`endif
                    end
                end
`ifdef LIEAT_SRAM_DELAY_EN
                R_WAIT: begin
                    // Reload on exit so the first beat reflects writes made during the wait
                    if (r_wait_cnt == 32'(DELAY - 1)) begin
                        r_rdata   <= w_rd_ok ? w_mem_rdata : 64'd0;
                        r_rresp   <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
                        r_rlast   <= w_rd_last;
                        r_rvalid  <= 1'b1;
                        r_r_state <= R_DATA;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 32'd1;
                    end
                end
`endif
                R_DATA: begin
                    if (io_slave_rready) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_arready <= 1'b1;
                            r_r_state <= R_IDLE;
                        end else begin
                            r_raddr <= w_rd_addr;
                            r_rcnt  <= w_rd_cnt;
                            r_rdata <= w_rd_ok ? w_mem_rdata : 64'd0;
                            r_rresp <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
                            r_rlast <= w_rd_last;
                        end
                    end
                end
                default: r_r_state <= R_IDLE;
            endcase
        end
    end

    assign io_slave_awready = r_awready;
    assign io_slave_wready  = r_wready;
    assign io_slave_bvalid  = r_bvalid;
    assign io_slave_bresp   = r_bresp;
    assign io_slave_bid     = r_bid;
    assign io_slave_arready = r_arready;
    assign io_slave_rvalid  = r_rvalid;
    assign io_slave_rresp   = r_rresp;
    assign io_slave_rdata   = r_rdata;
    assign io_slave_rlast   = r_rlast;
    assign io_slave_rid     = r_rid;

endmodule
